sobel_frame_sequencer: RTL and testbench
========================================

// Module: sobel_frame_sequencer
// PURPOSE
//  Frame-level controller for the Sobel gradient/direction datapath. On a start
//  strobe it primes the pipeline, then walks the pixel address range in bursts
//  of BEATS process cycles separated by PAUSE idle cycles, honouring a
//  downstream stall. It then drains the pipeline and pulses frameDone.
//  Its started/process/pixelCounter outputs gate the direction and magnitude stages.
// PARAMETERS
//  MINPIXEL          770     first pixel address processed (in two rows/cols)
//  MAXPIXEL          523518  upper bound; last address issued is the largest <= MAXPIXEL
//  BEATS             4       process cycles per burst (>=1)
//  PAUSE             1       idle cycles between bursts (0 = no PAUSE state)
//  COUNTSTEP         2       address increment per process cycle (>=1)
//  PIXELCOUNTERWIDTH 24      width of pixelCounter
//  PRIME             2       pipeline-fill cycles before first process (>=1)
//  DRAIN             2       pipeline-flush cycles after last process (>=1)
// PORTS
//  clk           in   1     clock, all logic on posedge
//  reset         in   1     synchronous, active-high reset
//  startEn       in   1     start-of-frame request, sampled only in IDLE
//  stall         in   1     downstream not ready; freezes RUN
//  started       out  1     high from PRIME entry through end of DRAIN
//  process       out  1     high on each cycle a pixel address is issued
//  pixelCounter  out  PIXELCOUNTERWIDTH  address of current process cycle
//  busy          out  1     high in any state other than IDLE
//  frameDone     out  1     one-cycle pulse in DONE
// BEHAVIOUR
//  - All outputs registered. Reset (sync, wins over all): state=IDLE, started=0,
//    process=0, pixelCounter=0, busy=0, frameDone=0, beat/pause/phase counters=0.
//  - States: IDLE, PRIME, RUN, PAUSE, DRAIN, DONE.
//  - IDLE: startEn=1 -> PRIME; pixelCounter loads MINPIXEL; started=1. Else hold.
//  - PRIME: counts PRIME cycles, process=0, then -> RUN. Stall ignored.
//  - RUN, stall=0: process=1 with current pixelCounter; beatCnt++. After issuing
//    addr A: if A+COUNTSTEP > MAXPIXEL -> DRAIN; else pixelCounter=A+COUNTSTEP and,
//    if beatCnt reaches BEATS and PAUSE>0, -> PAUSE (beatCnt=0); else stay RUN.
//  - RUN, stall=1: process=0; pixelCounter, beatCnt held; stay RUN.
//  - PAUSE: process=0 for exactly PAUSE cycles regardless of stall, then -> RUN.
//  - End of range takes priority over burst boundary: no PAUSE before DRAIN.
//  - DRAIN: process=0, started=1 for DRAIN cycles, then -> DONE.
//  - DONE: frameDone=1, started=0 for one cycle, -> IDLE; pixelCounter holds
//    last issued address until next start.
//  - First process cycle: PRIME+1 cycles after the cycle startEn is sampled.
//  - startEn while busy is ignored (no queuing). startEn in DONE ignored.
//  - Address compare done in PIXELCOUNTERWIDTH+1 bits; no wrap at MAXPIXEL near
//    2^PIXELCOUNTERWIDTH-1.
//  - MINPIXEL > MAXPIXEL: exactly one process cycle at MINPIXEL, then DRAIN.
//  - Reset mid-frame: next cycle IDLE with all outputs at reset values.
// TESTING (MINPIXEL=10, MAXPIXEL=20, BEATS=2, PAUSE=1, COUNTSTEP=2, PRIME=2, DRAIN=2)
//  1 startEn at cycle 0 -> process at addrs 10,12,-,14,16,-,18,20 (- = pause);
//    first process cycle 3; frameDone one pulse 3 cycles after addr 20; 6 process pulses.
//  2 stall high for 3 cycles while addr 14 pending -> process low 3 cycles,
//    14 then issued, sequence and count unchanged; frameDone delayed 3 cycles.
//  3 MAXPIXEL=19 -> last address 18, no address > 19 ever issued, 5 process pulses.
//  4 reset asserted in RUN at addr 16 -> next cycle busy=0, process=0,
//    pixelCounter=0; new startEn restarts at 10.
//  5 startEn pulsed during RUN and DONE -> ignored; exactly one frameDone per frame.
//  6 PAUSE=0, BEATS=2 -> addrs 10..20 on 6 consecutive cycles, no gaps.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer
// Frame-level controller for the Sobel gradient/direction datapath. A start
// request primes the pipeline, the pixel address range is then walked in
// bursts of BEATS process cycles separated by PAUSE idle cycles (a downstream
// stall freezes the walk), the pipeline is drained and frameDone pulses once.
//
// Ports:
//   clk           in   clock, everything on the rising edge
//   reset         in   synchronous active-high reset, overrides everything
//   startEn       in   start-of-frame request, only honoured while idle
//   stall         in   downstream not ready; holds back address issue
//   started       out  high from pipeline prime through end of drain
//   process       out  high on each cycle a pixel address is issued
//   pixelCounter  out  address issued this cycle (holds the last one otherwise)
//   busy          out  high whenever a frame is in flight, including DONE
//   frameDone     out  one-cycle end-of-frame pulse
//
// Every output is a flop. The issue decision for a cycle is therefore taken at
// the clock edge that starts that cycle, using the stall value sampled there.
module sobel_frame_sequencer #(
  parameter int unsigned MINPIXEL          = 770,
  parameter int unsigned MAXPIXEL          = 523518,
  parameter int unsigned BEATS             = 4,
  parameter int unsigned PAUSE             = 1,
  parameter int unsigned COUNTSTEP         = 2,
  parameter int unsigned PIXELCOUNTERWIDTH = 24,
  parameter int unsigned PRIME             = 2,
  parameter int unsigned DRAIN             = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startEn,
  input  logic                         stall,
  output logic                         started,
  output logic                         process,
  output logic [PIXELCOUNTERWIDTH-1:0] pixelCounter,
  output logic                         busy,
  output logic                         frameDone
);

  localparam int unsigned W = PIXELCOUNTERWIDTH;

  // One shared phase counter times PRIME, PAUSE and DRAIN, so it is sized
  // for the longest of the three.
  localparam int unsigned PHASE_MAX =
    (PRIME > DRAIN) ? ((PRIME > PAUSE) ? PRIME : PAUSE)
                    : ((DRAIN > PAUSE) ? DRAIN : PAUSE);
  localparam int unsigned PHASEW = $clog2(PHASE_MAX + 1);
  localparam int unsigned BEATW  = $clog2(BEATS + 1);

  localparam logic [PHASEW-1:0] PRIME_LAST = PHASEW'(PRIME - 1);
  localparam logic [PHASEW-1:0] DRAIN_LAST = PHASEW'(DRAIN - 1);
  localparam logic [PHASEW-1:0] PAUSE_LAST = PHASEW'((PAUSE > 0) ? PAUSE - 1 : 0);
  localparam logic              HAS_PAUSE  = (PAUSE != 0);
  localparam logic [BEATW-1:0]  BEATS_V    = BEATW'(BEATS);

  // Addresses are compared one bit wider than the counter so that a range
  // ending near the top of the counter never wraps back to a small address.
  localparam logic [W:0] MIN_EXT  = (W+1)'(MINPIXEL);
  localparam logic [W:0] MAX_EXT  = (W+1)'(MAXPIXEL);
  localparam logic [W:0] STEP_EXT = (W+1)'(COUNTSTEP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_RUN,
    ST_PAUSE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PHASEW-1:0] phase_q, phase_d;
  logic [BEATW-1:0]  beat_q, beat_d;
  logic              burst_end_q, burst_end_d;
  logic              first_q, first_d;
  logic              started_q, started_d;
  logic              process_q, process_d;
  logic [W-1:0]      pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [W:0]        next_ext;
  logic              last_issue;
  logic [W-1:0]      issue_addr;
  logic [BEATW-1:0]  beat_inc;
  logic              enter_run;

  // pc_q is the address issued on the current cycle whenever process_q is
  // high. The very first issue of a frame uses the preloaded MINPIXEL; every
  // later issue advances by COUNTSTEP from the previous one.
  always_comb begin
    next_ext   = {1'b0, pc_q} + STEP_EXT;
    last_issue = (next_ext > MAX_EXT);
    issue_addr = first_q ? pc_q : next_ext[W-1:0];
    beat_inc   = beat_q + BEATW'(1);
  end

  // Next-state and registered-output logic. enter_run collects the three
  // places that lead into an issue slot (end of PRIME, end of PAUSE, and
  // staying in RUN); the stall check for that slot happens once, below.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    beat_d      = beat_q;
    burst_end_d = burst_end_q;
    first_d     = first_q;
    started_d   = started_q;
    process_d   = 1'b0;
    pc_d        = pc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    enter_run   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (startEn) begin
          state_d   = ST_PRIME;
          phase_d   = '0;
          beat_d    = '0;
          first_d   = 1'b1;
          pc_d      = MIN_EXT[W-1:0];
          started_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      ST_PRIME: begin
        if (phase_q == PRIME_LAST) begin
          phase_d   = '0;
          enter_run = 1'b1;
        end else begin
          phase_d = phase_q + PHASEW'(1);
        end
      end

      ST_RUN: begin
        // End of range wins over a burst boundary, so the last burst never
        // pauses before draining.
        if (process_q && last_issue) begin
          state_d = ST_DRAIN;
          phase_d = '0;
        end else if (process_q && burst_end_q && HAS_PAUSE) begin
          state_d = ST_PAUSE;
          phase_d = '0;
        end else begin
          enter_run = 1'b1;
        end
      end

      ST_PAUSE: begin
        if (phase_q == PAUSE_LAST) begin
          phase_d   = '0;
          enter_run = 1'b1;
        end else begin
          phase_d = phase_q + PHASEW'(1);
        end
      end

      ST_DRAIN: begin
        if (phase_q == DRAIN_LAST) begin
          state_d   = ST_DONE;
          phase_d   = '0;
          started_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          phase_d = phase_q + PHASEW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Issue slot: with stall low an address goes out this coming cycle and
    // the burst position advances; with stall high everything is held.
    if (enter_run) begin
      state_d = ST_RUN;
      if (!stall) begin
        process_d = 1'b1;
        pc_d      = issue_addr;
        first_d   = 1'b0;
        if (beat_inc == BEATS_V) begin
          beat_d      = '0;
          burst_end_d = 1'b1;
        end else begin
          beat_d      = beat_inc;
          burst_end_d = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset returns every flop to zero / IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      beat_q      <= '0;
      burst_end_q <= 1'b0;
      first_q     <= 1'b0;
      started_q   <= 1'b0;
      process_q   <= 1'b0;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      beat_q      <= beat_d;
      burst_end_q <= burst_end_d;
      first_q     <= first_d;
      started_q   <= started_d;
      process_q   <= process_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign started      = started_q;
  assign process      = process_q;
  assign pixelCounter = pc_q;
  assign busy         = busy_q;
  assign frameDone    = done_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Testbench for sobel_frame_sequencer. Five instances with different
// parameter sets share one set of inputs:
//   0: MIN 10  MAX 20  BEATS 2 PAUSE 1 PRIME 2 DRAIN 2  (reference set)
//   1: as 0 but MAX 19                         (range not a step multiple)
//   2: as 0 but PAUSE 0                        (no gaps)
//   3: MIN 30 > MAX 20                         (single issue)
//   4: 8-bit counter, MIN 250 MAX 255, BEATS 3 PAUSE 2 PRIME 3 DRAIN 1
module tb_sobel_frame_sequencer;

  localparam int NDUT  = 5;
  localparam int NRAND = 400;
  localparam int STEP  = 2;

  localparam int unsigned P_MIN[NDUT]   = '{10, 10, 10, 30, 250};
  localparam int unsigned P_MAX[NDUT]   = '{20, 19, 20, 20, 255};
  localparam int unsigned P_BEATS[NDUT] = '{2, 2, 2, 2, 3};
  localparam int unsigned P_PAUSE[NDUT] = '{1, 1, 0, 1, 2};
  localparam int unsigned P_PRIME[NDUT] = '{2, 2, 2, 2, 3};
  localparam int unsigned P_DRAIN[NDUT] = '{2, 2, 2, 2, 1};

  typedef struct packed {
    logic        proc;
    logic        started;
    logic        busy;
    logic        done;
    logic [23:0] pc;
  } outs_t;

  typedef struct {
    logic  startEn;
    logic  stall;
    outs_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startEn = 1'b0;
  logic        stall = 1'b0;

  logic        dProc[NDUT];
  logic        dStarted[NDUT];
  logic        dBusy[NDUT];
  logic        dDone[NDUT];
  logic [23:0] dPc[NDUT];
  logic [7:0]  pcE;

  int checks = 0;
  int errors = 0;

  bit    rStart[NRAND];
  bit    rStall[NRAND];
  outs_t expTrace[NDUT][NRAND];
  vec_t  tbl[15];

  always #5 clk = ~clk;

  // The four 24-bit instances come from the parameter tables.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sobel_frame_sequencer #(
      .MINPIXEL(P_MIN[g]), .MAXPIXEL(P_MAX[g]), .BEATS(P_BEATS[g]),
      .PAUSE(P_PAUSE[g]), .COUNTSTEP(STEP), .PIXELCOUNTERWIDTH(24),
      .PRIME(P_PRIME[g]), .DRAIN(P_DRAIN[g])
    ) dut (
      .clk(clk), .reset(reset), .startEn(startEn), .stall(stall),
      .started(dStarted[g]), .process(dProc[g]), .pixelCounter(dPc[g]),
      .busy(dBusy[g]), .frameDone(dDone[g])
    );
  end

  // Narrow-counter instance whose range ends at the counter's top value.
  sobel_frame_sequencer #(
    .MINPIXEL(P_MIN[4]), .MAXPIXEL(P_MAX[4]), .BEATS(P_BEATS[4]),
    .PAUSE(P_PAUSE[4]), .COUNTSTEP(STEP), .PIXELCOUNTERWIDTH(8),
    .PRIME(P_PRIME[4]), .DRAIN(P_DRAIN[4])
  ) dutE (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall),
    .started(dStarted[4]), .process(dProc[4]), .pixelCounter(pcE),
    .busy(dBusy[4]), .frameDone(dDone[4])
  );
  assign dPc[4] = {16'h0, pcE};

  function automatic outs_t mk(bit p, bit s, bit b, bit dn, int pc);
    outs_t o;
    o.proc    = p;
    o.started = s;
    o.busy    = b;
    o.done    = dn;
    o.pc      = 24'(pc);
    return o;
  endfunction

  function automatic outs_t actual(int d);
    return mk(dProc[d], dStarted[d], dBusy[d], dDone[d], int'(dPc[d]));
  endfunction

  // Drive one cycle of inputs away from the active edge, then step past it
  // so the outputs observed afterwards are the ones produced by that edge.
  task automatic applyStimulus(input logic r, input logic s, input logic st);
    @(negedge clk);
    reset   = r;
    startEn = s;
    stall   = st;
    @(posedge clk);
    #1;
  endtask

  // Compare the whole output bundle of one instance with an expected record.
  task automatic checkOutput(input int d, input string name, input int idx, input outs_t e);
    outs_t a;
    a = actual(d);
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s dut%0d step %0d: got proc=%0b started=%0b busy=%0b done=%0b pc=%0d, expected proc=%0b started=%0b busy=%0b done=%0b pc=%0d",
               name, d, idx, a.proc, a.started, a.busy, a.done, a.pc,
               e.proc, e.started, e.busy, e.done, e.pc);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int put(int d, int t, bit p, bit s, bit b, bit dn, int pc);
    if (t < NRAND) expTrace[d][t] = mk(p, s, b, dn, pc);
    return t + 1;
  endfunction

  // Reference model: works at the level of a frame. For each accepted start
  // it lists the addresses the frame must issue, then lays them onto the
  // cycle timeline: PRIME cycles, one address per unstalled slot, PAUSE
  // cycles after every full burst that is not the last, DRAIN cycles, one
  // DONE cycle, and one cycle in which a new start cannot yet be seen.
  task automatic buildModel(input int d);
    int t;
    int pc;
    int a;
    int addrs[$];
    t  = 0;
    pc = 0;
    while (t < NRAND) begin
      if (!rStart[t]) begin
        t = put(d, t, 0, 0, 0, 0, pc);
        continue;
      end
      addrs.delete();
      a = int'(P_MIN[d]);
      do begin
        addrs.push_back(a);
        a += STEP;
      end while (a <= int'(P_MAX[d]));
      pc = int'(P_MIN[d]);
      for (int k = 0; k < int'(P_PRIME[d]); k++) t = put(d, t, 0, 1, 1, 0, pc);
      for (int i = 0; i < addrs.size(); i++) begin
        while (t < NRAND && rStall[t]) t = put(d, t, 0, 1, 1, 0, pc);
        pc = addrs[i];
        t  = put(d, t, 1, 1, 1, 0, pc);
        if (i != addrs.size() - 1 && ((i + 1) % int'(P_BEATS[d])) == 0)
          for (int k = 0; k < int'(P_PAUSE[d]); k++) t = put(d, t, 0, 1, 1, 0, pc);
      end
      for (int k = 0; k < int'(P_DRAIN[d]); k++) t = put(d, t, 0, 1, 1, 0, pc);
      t = put(d, t, 0, 0, 1, 1, pc);
      t = put(d, t, 0, 0, 0, 0, pc);
    end
  endtask

  // Directed vectors for instance 0: one whole frame starting on the first
  // row, with stall during PRIME and at end of range (both must be ignored)
  // and start requests during RUN and DONE (both must be ignored).
  task automatic fillTable();
    tbl[0]  = '{1'b1, 1'b0, mk(0, 1, 1, 0, 10)};
    tbl[1]  = '{1'b0, 1'b1, mk(0, 1, 1, 0, 10)};
    tbl[2]  = '{1'b0, 1'b0, mk(1, 1, 1, 0, 10)};
    tbl[3]  = '{1'b0, 1'b0, mk(1, 1, 1, 0, 12)};
    tbl[4]  = '{1'b0, 1'b0, mk(0, 1, 1, 0, 12)};
    tbl[5]  = '{1'b1, 1'b0, mk(1, 1, 1, 0, 14)};
    tbl[6]  = '{1'b0, 1'b0, mk(1, 1, 1, 0, 16)};
    tbl[7]  = '{1'b0, 1'b0, mk(0, 1, 1, 0, 16)};
    tbl[8]  = '{1'b0, 1'b0, mk(1, 1, 1, 0, 18)};
    tbl[9]  = '{1'b0, 1'b0, mk(1, 1, 1, 0, 20)};
    tbl[10] = '{1'b0, 1'b1, mk(0, 1, 1, 0, 20)};
    tbl[11] = '{1'b0, 1'b0, mk(0, 1, 1, 0, 20)};
    tbl[12] = '{1'b0, 1'b0, mk(0, 0, 1, 1, 20)};
    tbl[13] = '{1'b1, 1'b0, mk(0, 0, 0, 0, 20)};
    tbl[14] = '{1'b0, 1'b0, mk(0, 0, 0, 0, 20)};
  endtask

  initial begin
    int cntA, cntB, maxB, cntC, firstC, lastC, cntD, cntE, lastE, doneA;
    bit found;

    $display("[TB] start");

    // Reset state on every instance.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) checkOutput(d, "reset_state", 0, mk(0, 0, 0, 0, 0));

    // Directed frame; other instances are tallied while it runs.
    fillTable();
    cntA = 0; cntB = 0; maxB = 0; cntC = 0; firstC = -1; lastC = -1;
    cntD = 0; cntE = 0; lastE = 0; doneA = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, tbl[i].startEn, tbl[i].stall);
      checkOutput(0, "table", i, tbl[i].exp);
      if (dProc[0]) cntA++;
      if (dDone[0]) doneA++;
      if (dProc[1]) begin
        cntB++;
        if (int'(dPc[1]) > maxB) maxB = int'(dPc[1]);
      end
      if (dProc[2]) begin
        if (firstC < 0) firstC = i;
        lastC = i;
        cntC++;
      end
      if (dProc[3]) cntD++;
      if (dProc[4]) begin
        cntE++;
        lastE = int'(dPc[4]);
      end
    end
    checkCount("ref_process_pulses", cntA, 6);
    checkCount("ref_frame_done_pulses", doneA, 1);
    checkCount("max19_process_pulses", cntB, 5);
    checkCount("max19_highest_addr", maxB, 18);
    checkCount("nopause_process_pulses", cntC, 6);
    checkCount("nopause_span", lastC - firstC, 5);
    checkCount("min_gt_max_pulses", cntD, 1);
    checkCount("narrow_pulses", cntE, 3);
    checkCount("narrow_last_addr", lastE, 254);

    // Reset in the middle of RUN, then a clean restart.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (dProc[0] && dPc[0] == 24'd16) found = 1'b1;
    end
    checkCount("reach_addr16_in_time", int'(found), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput(0, "reset_mid_run", 0, mk(0, 0, 0, 0, 0));
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput(0, "restart_prime", 0, mk(0, 1, 1, 0, 10));
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput(0, "restart_first_issue", 0, mk(1, 1, 1, 0, 10));

    // Random starts and stalls on all instances against the frame model.
    for (int t = 0; t < NRAND; t++) begin
      rStart[t] = ($urandom_range(0, 7) == 0);
      rStall[t] = ($urandom_range(0, 9) < 3);
    end
    for (int d = 0; d < NDUT; d++) buildModel(d);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < NRAND; t++) begin
      applyStimulus(1'b0, rStart[t], rStall[t]);
      for (int d = 0; d < NDUT; d++) checkOutput(d, "random", t, expTrace[d][t]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
